// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: Enable/MFC bus master for an async 256-byte RAM.
// Splits dwords into two big-endian word beats; flags misalign/timeout.
module mem_access_ctrl #(
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 0
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Req,
  input  logic        RW,
  input  logic [7:0]  Addr,
  input  logic [1:0]  Size,
  input  logic [63:0] WData,
  output logic [63:0] RData,
  output logic        Done,
  output logic        Err,
  output logic        Busy,
  output logic        MemEnable,
  output logic        MemRW,
  output logic [7:0]  MemAddr,
  output logic [1:0]  MemSize,
  output logic [31:0] MemDataIn,
  input  logic [31:0] MemDataOut,
  input  logic        MFC
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RELEASE,
    DONE
  } state_t;

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TLAST =
    TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_t state_q, state_d;

  logic        beat_q, beat_d;
  logic        dw_q, dw_d;
  logic        err_q, err_d;
  logic [31:0] wlo_q, wlo_d;
  logic [63:0] rbuf_q, rbuf_d;
  logic [63:0] rdata_q, rdata_d;

  logic        men_q, men_d;
  logic        mrw_q, mrw_d;
  logic [7:0]  madr_q, madr_d;
  logic [1:0]  msz_q, msz_d;
  logic [31:0] mdin_q, mdin_d;

  logic [SYNC_STAGES-1:0] sync_q;
  logic [TW-1:0]          tmr_q, tmr_d;

  logic mfc_s;
  logic mis;
  logic expire;

  assign mfc_s  = sync_q[SYNC_STAGES-1];
  assign expire = (TIMEOUT > 0) && (tmr_q == TLAST);

  // Alignment check on the incoming request
  always_comb begin
    mis = 1'b0;
    case (Size)
      2'b01:   mis = Addr[0];
      2'b10:   mis = |Addr[1:0];
      2'b11:   mis = |Addr[2:0];
      default: mis = 1'b0;
    endcase
  end

  // MFC crosses in from the RAM's domain through a flop chain
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], MFC};
    end
  end

  // State and per-phase timer registers
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      tmr_q   <= '0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
    end
  end

  // Request, read data and RAM-side output registers
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      beat_q  <= 1'b0;
      dw_q    <= 1'b0;
      err_q   <= 1'b0;
      wlo_q   <= '0;
      rbuf_q  <= '0;
      rdata_q <= '0;
      men_q   <= 1'b0;
      mrw_q   <= 1'b0;
      madr_q  <= '0;
      msz_q   <= '0;
      mdin_q  <= '0;
    end else begin
      beat_q  <= beat_d;
      dw_q    <= dw_d;
      err_q   <= err_d;
      wlo_q   <= wlo_d;
      rbuf_q  <= rbuf_d;
      rdata_q <= rdata_d;
      men_q   <= men_d;
      mrw_q   <= mrw_d;
      madr_q  <= madr_d;
      msz_q   <= msz_d;
      mdin_q  <= mdin_d;
    end
  end

  // Next-state, beat sequencing and read capture
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    dw_d    = dw_q;
    err_d   = err_q;
    wlo_d   = wlo_q;
    rbuf_d  = rbuf_q;
    rdata_d = rdata_q;
    mrw_d   = mrw_q;
    madr_d  = madr_q;
    msz_d   = msz_q;
    mdin_d  = mdin_q;
    tmr_d   = tmr_q + TW'(1);

    unique case (state_q)
      IDLE: begin
        if (Req) begin
          err_d  = mis;
          beat_d = 1'b0;
          dw_d   = (Size == 2'b11);
          wlo_d  = WData[31:0];
          rbuf_d = '0;
          if (mis) begin
            state_d = DONE;
          end else begin
            state_d = ACCESS;
            mrw_d   = RW;
            madr_d  = Addr;
            msz_d   = (Size == 2'b11) ? 2'b10 : Size;
            mdin_d  = (Size == 2'b11) ? WData[63:32]
                                      : WData[31:0];
          end
        end
      end

      ACCESS: begin
        if (expire) begin
          err_d   = 1'b1;
          state_d = DONE;
        end else if (mfc_s) begin
          state_d = RELEASE;
          if (mrw_q) begin
            case (msz_q)
              2'b00: rbuf_d = {56'b0, MemDataOut[7:0]};
              2'b01: rbuf_d = {48'b0, MemDataOut[15:0]};
              default: begin
                if (!dw_q) begin
                  rbuf_d = {32'b0, MemDataOut};
                end else if (beat_q) begin
                  rbuf_d[31:0] = MemDataOut;
                end else begin
                  rbuf_d[63:32] = MemDataOut;
                end
              end
            endcase
          end
        end
      end

      RELEASE: begin
        if (expire) begin
          err_d   = 1'b1;
          state_d = DONE;
        end else if (!mfc_s) begin
          if (dw_q && !beat_q) begin
            beat_d  = 1'b1;
            madr_d  = madr_q + 8'd4;
            mdin_d  = wlo_q;
            state_d = ACCESS;
          end else begin
            state_d = DONE;
            if (mrw_q) begin
              rdata_d = rbuf_d;
            end
          end
        end
      end

      DONE: begin
        state_d = IDLE;
      end
    endcase

    if (state_d != state_q) begin
      tmr_d = '0;
    end

    men_d = (state_q == ACCESS) && (state_d == ACCESS);
  end

  assign RData     = rdata_q;
  assign Done      = (state_q == DONE);
  assign Err       = (state_q == DONE) && err_q;
  assign Busy      = (state_q == ACCESS) || (state_q == RELEASE);
  assign MemEnable = men_q;
  assign MemRW     = mrw_q;
  assign MemAddr   = madr_q;
  assign MemSize   = msz_q;
  assign MemDataIn = mdin_q;

endmodule
